// File: rtl/cuda_writeback_arbiter_if.sv
// cuda_writeback_arbiter_if: ALU/FPU/LSU result channels, register-file write port and status
// master = result producers and register file side, slave = arbiter
// channels: <src>_valid/_ready/_addr/_data (+ lsu_is_float); write port: write_en/_addr/_data/_is_float
// status: busy, drop_cnt
interface cuda_writeback_arbiter_if;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        fpu_valid, fpu_ready;
  logic [4:0]  fpu_addr;
  logic [31:0] fpu_data;
  logic        lsu_valid, lsu_ready, lsu_is_float;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        write_en, write_is_float, busy;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [7:0]  drop_cnt;
  modport master(
    output alu_valid, alu_addr, alu_data, fpu_valid, fpu_addr, fpu_data,
           lsu_valid, lsu_addr, lsu_data, lsu_is_float,
    input  alu_ready, fpu_ready, lsu_ready, write_en, write_addr, write_data,
           write_is_float, busy, drop_cnt
  );
  modport slave(
    input  alu_valid, alu_addr, alu_data, fpu_valid, fpu_addr, fpu_data,
           lsu_valid, lsu_addr, lsu_data, lsu_is_float,
    output alu_ready, fpu_ready, lsu_ready, write_en, write_addr, write_data,
           write_is_float, busy, drop_cnt
  );
endinterface

// File: rtl/cuda_writeback_arbiter.sv
// cuda_writeback_arbiter: per-source result FIFOs merged round-robin onto one register-file write port
// ports: clk, rst (async, active-high), bus (slave modport: three result channels, write port, busy, drop_cnt)
module cuda_writeback_arbiter #(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  cuda_writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [37:0] entry_t;
  logic [2:0] v, rdy, push, drop, ne, pop;
  logic [4:0] a [3];
  entry_t e [3];
  entry_t mem [3][DEPTH];
  logic [AW-1:0] wp [3];
  logic [AW-1:0] rp [3];
  logic [AW:0] cnt [3];
  logic [1:0] lg, c1, c2, g;
  logic gv, we, wf;
  logic [4:0] wa;
  logic [31:0] wd;
  logic [7:0] dcnt;
  logic [1:0] ndrop;
  logic [8:0] dsum;
  assign v = {bus.lsu_valid, bus.fpu_valid, bus.alu_valid};
  assign a[0] = bus.alu_addr;
  assign a[1] = bus.fpu_addr;
  assign a[2] = bus.lsu_addr;
  assign e[0] = {bus.alu_addr, bus.alu_data, 1'b0};
  assign e[1] = {bus.fpu_addr, bus.fpu_data, 1'b1};
  assign e[2] = {bus.lsu_addr, bus.lsu_data, bus.lsu_is_float};
  for (genvar i = 0; i < 3; i++) begin : g_src
    assign rdy[i]  = cnt[i] < (AW+1)'(DEPTH);
    assign ne[i]   = cnt[i] != '0;
    assign push[i] = v[i] & rdy[i] & (a[i] != 5'd0);
    assign drop[i] = v[i] & rdy[i] & (a[i] == 5'd0);
  end
  // search starts at the source after the last grant and wraps back to it
  always_comb begin
    c1 = (lg == 2'd2) ? 2'd0 : lg + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    gv = |ne;
    g = ne[c1] ? c1 : ne[c2] ? c2 : lg;
    pop = gv ? (3'b001 << g) : 3'b000;
    ndrop = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    dsum = {1'b0, dcnt} + {7'd0, ndrop};
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (push[i]) mem[i][wp[i]] <= e[i];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end
      lg <= 2'd2;
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
      wf <= 1'b0;
      dcnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wp[i] <= wp[i] + AW'(1);
        if (pop[i]) rp[i] <= rp[i] + AW'(1);
        cnt[i] <= (push[i] && !pop[i]) ? cnt[i] + (AW+1)'(1) :
                  (!push[i] && pop[i]) ? cnt[i] - (AW+1)'(1) : cnt[i];
      end
      we <= gv;
      if (gv) begin
        lg <= g;
        {wa, wd, wf} <= mem[g][rp[g]];
      end
      dcnt <= dsum[8] ? 8'hff : dsum[7:0];
    end
  assign bus.alu_ready = rdy[0];
  assign bus.fpu_ready = rdy[1];
  assign bus.lsu_ready = rdy[2];
  assign bus.write_en = we;
  assign bus.write_addr = wa;
  assign bus.write_data = wd;
  assign bus.write_is_float = wf;
  assign bus.drop_cnt = dcnt;
  assign bus.busy = gv | we;
endmodule

// File: tb/tb_cuda_writeback_arbiter.sv
// tb_cuda_writeback_arbiter: queue-based reference model with per-cycle compare plus literal checks
module tb_cuda_writeback_arbiter;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic rst = 0;
  bit cmp_on = 0;
  int tests = 0;
  int fails = 0;
  cuda_writeback_arbiter_if bus();
  cuda_writeback_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [37:0] q [3][$];
  int mlg = 2;
  int mdrop = 0;
  logic ewe = 0, ef = 0;
  logic [4:0] ea = 0;
  logic [31:0] ed = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      mlg = 2; mdrop = 0; ewe = 0; ea = 0; ed = 0; ef = 0;
    end else begin
      int sz [3];
      bit vv [3];
      logic [4:0] aa [3];
      logic [31:0] dd [3];
      logic ff [3];
      logic [37:0] hd;
      int s, nd;
      bit got;
      vv[0] = bus.alu_valid; aa[0] = bus.alu_addr; dd[0] = bus.alu_data; ff[0] = 1'b0;
      vv[1] = bus.fpu_valid; aa[1] = bus.fpu_addr; dd[1] = bus.fpu_data; ff[1] = 1'b1;
      vv[2] = bus.lsu_valid; aa[2] = bus.lsu_addr; dd[2] = bus.lsu_data; ff[2] = bus.lsu_is_float;
      for (int i = 0; i < 3; i++) sz[i] = q[i].size();
      got = 0;
      for (int k = 1; k <= 3; k++) begin
        s = (mlg + k) % 3;
        if (!got && sz[s] > 0) begin
          got = 1;
          hd = q[s].pop_front();
          mlg = s;
        end
      end
      ewe = got;
      if (got) {ea, ed, ef} = hd;
      nd = 0;
      for (int i = 0; i < 3; i++)
        if (vv[i] && sz[i] < DEPTH) begin
          if (aa[i] != 5'd0) q[i].push_back({aa[i], dd[i], ff[i]});
          else nd++;
        end
      mdrop = (mdrop + nd > 255) ? 255 : mdrop + nd;
    end
  end
  always @(negedge clk) if (cmp_on) begin
    chk("alu_ready", 32'(bus.alu_ready), 32'(q[0].size() < DEPTH));
    chk("fpu_ready", 32'(bus.fpu_ready), 32'(q[1].size() < DEPTH));
    chk("lsu_ready", 32'(bus.lsu_ready), 32'(q[2].size() < DEPTH));
    chk("write_en", 32'(bus.write_en), 32'(ewe));
    chk("write_addr", 32'(bus.write_addr), 32'(ea));
    chk("write_data", bus.write_data, ed);
    chk("write_is_float", 32'(bus.write_is_float), 32'(ef));
    chk("busy", 32'(bus.busy), 32'(q[0].size() > 0 || q[1].size() > 0 || q[2].size() > 0 || ewe));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(mdrop));
  end
  task automatic idle();
    bus.alu_valid = 0; bus.fpu_valid = 0; bus.lsu_valid = 0;
  endtask
  task automatic drive(input int src, input logic [4:0] ad, input logic [31:0] d, input logic f);
    case (src)
      0: begin bus.alu_valid = 1; bus.alu_addr = ad; bus.alu_data = d; end
      1: begin bus.fpu_valid = 1; bus.fpu_addr = ad; bus.fpu_data = d; end
      default: begin bus.lsu_valid = 1; bus.lsu_addr = ad; bus.lsu_data = d; bus.lsu_is_float = f; end
    endcase
  endtask
  task automatic do_reset();
    @(posedge clk); #2 rst = 1; idle();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
  endtask
  initial begin
    idle();
    bus.alu_addr = 0; bus.alu_data = 0; bus.fpu_addr = 0; bus.fpu_data = 0;
    bus.lsu_addr = 0; bus.lsu_data = 0; bus.lsu_is_float = 0;
    #1 rst = 1;
    @(negedge clk);
    cmp_on = 1;
    chk("rst_write_en", 32'(bus.write_en), 0);
    chk("rst_ready", 32'({bus.alu_ready, bus.fpu_ready, bus.lsu_ready}), 32'h7);
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 0);
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    drive(0, 5'd5, 32'hDEADBEEF, 0);
    @(negedge clk); idle();
    @(negedge clk);
    chk("single_we", 32'(bus.write_en), 1);
    chk("single_addr", 32'(bus.write_addr), 5);
    chk("single_data", bus.write_data, 32'hDEADBEEF);
    chk("single_float", 32'(bus.write_is_float), 0);
    @(negedge clk);
    chk("single_we_off", 32'(bus.write_en), 0);
    chk("single_busy_off", 32'(bus.busy), 0);
    do_reset();
    drive(0, 5'd1, 32'h11, 0); drive(1, 5'd2, 32'h22, 0); drive(2, 5'd3, 32'h33, 1);
    @(negedge clk); idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rr_we", 32'(bus.write_en), 1);
      chk("rr_addr", 32'(bus.write_addr), 32'(k + 1));
      chk("rr_float", 32'(bus.write_is_float), (k == 0) ? 0 : 1);
    end
    for (int k = 0; k < 30; k++) begin
      drive(0, 5'(1 + k % 31), 32'(k * 3), 0);
      drive(1, 5'(1 + (k + 7) % 31), 32'(k * 3 + 1), 0);
      drive(2, 5'(1 + (k + 13) % 31), 32'(k * 3 + 2), 5'(k) % 2 == 0);
      @(negedge clk);
    end
    idle();
    repeat (8) @(negedge clk);
    chk("stream_drained_busy", 32'(bus.busy), 0);
    do_reset();
    drive(1, 5'd0, 32'h5, 0);
    @(negedge clk); idle();
    chk("drop_one", 32'(bus.drop_cnt), 1);
    chk("drop_no_we", 32'(bus.write_en), 0);
    drive(1, 5'd0, 32'h6, 0);
    repeat (300) @(negedge clk);
    idle();
    chk("drop_sat", 32'(bus.drop_cnt), 255);
    do_reset();
    for (int k = 0; k < 400; k++) begin
      idle();
      for (int s = 0; s < 3; s++)
        if ($urandom_range(0, 1) == 1)
          drive(s, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    idle();
    do_reset();
    drive(0, 5'd7, 32'h70, 0); drive(1, 5'd8, 32'h80, 0); drive(2, 5'd9, 32'h90, 0);
    @(negedge clk); idle();
    @(posedge clk); #2 rst = 1;
    #1;
    chk("async_we", 32'(bus.write_en), 0);
    chk("async_ready", 32'({bus.alu_ready, bus.fpu_ready, bus.lsu_ready}), 32'h7);
    chk("async_busy", 32'(bus.busy), 0);
    @(posedge clk); #2 rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_no_write", 32'(bus.write_en), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cuda_writeback_arbiter.md
CUDA_WRITEBACK_ARBITER -- requirements
Module: cuda_writeback_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning per-source result FIFO depth; the value SHALL be a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports alu_valid (in, 1), alu_ready (out, 1), alu_addr (in, 5) and alu_data (in, 32), forming the integer ALU result channel.
REQ-005 SHALL have ports fpu_valid (in, 1), fpu_ready (out, 1), fpu_addr (in, 5) and fpu_data (in, 32), forming the FPU result channel.
REQ-006 SHALL have ports lsu_valid (in, 1), lsu_ready (out, 1), lsu_addr (in, 5), lsu_data (in, 32) and lsu_is_float (in, 1), forming the load result channel.
REQ-007 SHALL have ports write_en (out, 1), write_addr (out, 5), write_data (out, 32) and write_is_float (out, 1), which drive the thread register file write port.
REQ-008 SHALL have port busy, output, 1, high when any result is pending or being written.
REQ-009 SHALL have port drop_cnt, output, 8, a saturating count of results discarded for targeting r0.

Function
REQ-010 A handshake SHALL complete on a rising edge where valid and ready are both 1.
REQ-011 Each channel's ready SHALL equal (FIFO occupancy < DEPTH); there is no pass-through, so a full FIFO SHALL present ready=0 even in a cycle where it is popped.
REQ-012 A completed handshake with addr != 0 SHALL enqueue {addr, data, is_float}, where is_float is 0 for ALU, 1 for FPU and lsu_is_float for LSU.
REQ-013 A completed handshake with addr == 0 SHALL NOT enqueue; drop_cnt SHALL increment and saturate at 255, by +1 per dropping channel in that cycle, summed across channels and saturated.
REQ-014 On each edge where at least one FIFO is non-empty, the arbiter SHALL grant exactly one non-empty FIFO.
REQ-015 The grant SHALL follow round-robin order ALU(0) -> FPU(1) -> LSU(2), starting from the source after last_grant.
REQ-016 The granted FIFO SHALL pop its head on that grant edge.
REQ-017 On the grant edge, write_en, write_addr, write_data and write_is_float SHALL register the popped entry, with write_en=1 for exactly that one cycle per entry.
REQ-018 On an edge with no grant, write_en SHALL register 0, and write_addr, write_data and write_is_float SHALL hold their previous values.
REQ-019 last_grant SHALL update only on a grant.
REQ-020 Latency: an entry accepted at edge N into an empty FIFO, with no competing entries, SHALL appear with write_en=1 after edge N+1.
REQ-021 Order within a single source SHALL be preserved; order across sources is defined solely by arbitration order.
REQ-022 Sustained throughput SHALL be one write per cycle while any FIFO is non-empty.
REQ-023 A push and a pop on the same FIFO in the same edge SHALL both take effect, leaving occupancy unchanged.
REQ-024 busy SHALL equal (any FIFO non-empty) OR write_en.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 While rst=1: write_en=0, write_addr=0, write_data=0, write_is_float=0, busy=0 and drop_cnt=0.
REQ-027 While rst=1: all FIFOs SHALL be empty, all ready outputs SHALL be 1, and last_grant=LSU(2), so ALU holds first priority after reset.
REQ-028 Reset asserted mid-operation SHALL discard all pending entries immediately, forcing write_en=0 asynchronously.
REQ-029 Handshakes SHALL NOT be accepted on an edge where rst=1.

Verification
REQ-030 ALU addr=5, data=0xDEADBEEF accepted at edge N -> after edge N+1, write_en=1, addr=5, data=0xDEADBEEF, is_float=0 for one cycle; afterwards busy=0.
REQ-031 ALU/FPU/LSU valid in the same cycle with addr 1/2/3 and lsu_is_float=1 -> three consecutive writes to addr 1, 2, 3 with is_float 0, 1, 1.
REQ-032 All three channels valid continuously for 30 cycles with incrementing data, DEPTH=2 -> ready drops per channel, no entry is lost or duplicated, per-source order is preserved, and grants rotate 0, 1, 2.
REQ-033 FPU addr=0 accepted -> no write_en pulse and drop_cnt=1; 300 further addr=0 results -> drop_cnt=255.
REQ-034 rst pulsed while 2 entries are pending -> write_en=0 immediately, ready=1, and no stale write after reset is released.
